pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline-stage register. It is the next generation of the fixed ID/EX stage latch. It replaces the single register, stall-means-bubble latch with a valid/ready handshake and a 2-entry skid buffer, so `in_ready` is fully registered. It also adds a synchronous flush, output control-bit masking on bubbles, and saturating stall/starve performance counters. One instance sits between each pair of CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 128, width of the payload carried unmodified (operands, immediates, pc, addresses)
CTRL_W, 4, width of side-effect control bits (memwrite, memread, regwrite, memtoreg); forced to 0 whenever the output is not valid
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream stage presents an entry
in_ready  output  1  stage can accept an entry; registered
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bits
out_valid  output  1  entry available to downstream
out_ready  input  1  downstream accepts the entry
out_data  output  DATA_W  payload of the head entry
out_ctrl  output  CTRL_W  control bits of the head entry, masked by out_valid
flush  input  1  synchronous discard of all held entries
occupancy  output  2  number of held entries, 0..2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
starve_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1
cnt_clr  input  1  synchronous clear of both counters

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces the following, independent of clk.
  - State EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - out_data=0, out_ctrl=0, skid entry=0, stall_cnt=0, starve_cnt=0.
  - Reset may assert mid-transfer; any held entries are lost.
- Handshake definitions:
  - Input transfer (IX) occurs when in_valid & in_ready.
  - Output transfer (OX) occurs when out_valid & out_ready.
- Storage: head register H drives out_data/out_ctrl; skid register S holds one extra entry.
- State machine, evaluated per edge when flush=0:
  - EMPTY: IX -> H<=in, go to ONE. Otherwise stay.
  - ONE:
    - IX & !OX -> S<=in, go to FULL.
    - IX & OX -> H<=in, stay ONE (zero-bubble streaming, 1 entry per cycle).
    - !IX & OX -> go to EMPTY.
    - Neither -> hold.
  - FULL: in_ready=0, so no IX is possible.
    - OX -> H<=S, go to ONE.
    - Otherwise hold both entries.
- in_ready is a register equal to (next state != FULL). It never depends combinationally on out_ready.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY or streaming.
- Entries leave in strict acceptance order; no entry is duplicated or dropped except by flush or reset.
- out_valid = (state != EMPTY).
- out_ctrl = H.ctrl when out_valid=1, else all zeros. This guarantees bubbles carry no memwrite/regwrite side effects.
- out_data holds its last value when empty; it is not cleared.
- occupancy: EMPTY=0, ONE=1, FULL=2.
- flush=1 (highest priority after reset):
  - Next state is EMPTY, in_ready<=1.
  - An OX in the same cycle still counts as consumed by downstream.
  - An IX in the same cycle is discarded; upstream must flush that entry too.
- stall_cnt increments by 1 each cycle out_valid & !out_ready.
- starve_cnt increments by 1 each cycle !out_valid & out_ready.
- Both counters saturate at all-ones (no wrap).
- cnt_clr=1 zeroes both counters on the next edge and overrides an increment in the same cycle. Counters are unaffected by flush.

Test Plan:
1. Reset and streaming: assert rst_n=0 mid-cycle -> outputs zero and in_ready=1 before the next edge. Release, hold out_ready=1, drive in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, no gaps, occupancy stays 1, in_ready constantly 1.
2. Backpressure fill: hold out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0 from the following cycle, 0xC held by upstream. Then out_ready=1 -> out_data sequence 0xA, 0xB, 0xC, nothing lost or duplicated.
3. Control masking: push ctrl=4'b1111 then leave idle with out_ready=1 -> out_ctrl=4'b1111 for one cycle, then 4'b0000 with out_valid=0 while out_data retains the old payload.
4. Flush: with occupancy=2 (0x5, 0x6) and in_valid=0, assert flush for one cycle with out_ready=0 -> next cycle occupancy=0, out_valid=0, in_ready=1. A subsequent push of 0x7 emerges as the next output.
5. Flush collision: with occupancy=1, assert flush, in_valid=1 (data 0x9) and out_ready=1 together -> head consumed, 0x9 discarded, state EMPTY.
6. Counters: CNT_W=4, out_valid=1 and out_ready=0 held 20 cycles -> stall_cnt saturates at 15. Assert cnt_clr together with a stall cycle -> stall_cnt=0. 3 idle cycles with out_ready=1 -> starve_cnt=3.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid buffer,
// registered in_ready, synchronous flush, bubble control masking and saturating perf counters.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  starve_cnt,
  input  logic              cnt_clr
);

  // Encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [DATA_W-1:0] h_data_reg, s_data_reg;
  logic [CTRL_W-1:0] h_ctrl_reg, s_ctrl_reg;
  logic              in_ready_reg;
  logic [CNT_W-1:0]  stall_reg, starve_reg;

  logic ix, ox;
  logic load_h_in, load_h_s, load_s;

  assign out_valid = (state_reg != EMPTY);
  assign ix        = in_valid & in_ready_reg;
  assign ox        = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    load_h_in  = 1'b0;
    load_h_s   = 1'b0;
    load_s     = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (ix) begin
          load_h_in  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (ix && !ox) begin
          load_s     = 1'b1;
          state_next = FULL;
        end else if (ix && ox) begin
          load_h_in  = 1'b1;
        end else if (ox) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (ox) begin
          load_h_s   = 1'b1;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush drops held entries and any entry arriving this cycle.
    if (flush) begin
      state_next = EMPTY;
      load_h_in  = 1'b0;
      load_h_s   = 1'b0;
      load_s     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
      h_data_reg   <= '0;
      h_ctrl_reg   <= '0;
      s_data_reg   <= '0;
      s_ctrl_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
      if (load_h_in) begin
        h_data_reg <= in_data;
        h_ctrl_reg <= in_ctrl;
      end else if (load_h_s) begin
        h_data_reg <= s_data_reg;
        h_ctrl_reg <= s_ctrl_reg;
      end
      if (load_s) begin
        s_data_reg <= in_data;
        s_ctrl_reg <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg  <= '0;
      starve_reg <= '0;
    end else if (cnt_clr) begin
      stall_reg  <= '0;
      starve_reg <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_reg))
        stall_reg <= stall_reg + 1'b1;
      if (!out_valid && out_ready && !(&starve_reg))
        starve_reg <= starve_reg + 1'b1;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_data   = h_data_reg;
  assign out_ctrl   = out_valid ? h_ctrl_reg : '0;
  assign occupancy  = state_reg;
  assign stall_cnt  = stall_reg;
  assign starve_cnt = starve_reg;

endmodule
